// File: rtl/opr_sequencer_if.sv
// Handshake and strobe bundle between instruction decode, opr_sequencer and the acc/cy register.
// The decode/register side uses the master modport; the sequencer uses the slave modport.
interface opr_sequencer_if;
    logic       start;
    logic [8:0] opr;
    logic       accminus;
    logic       acczero;
    logic       cyout;
    logic       busy;
    logic       done;
    logic       clearacc;
    logic       clearcy;
    logic       compacc;
    logic       compcy;
    logic       accwrite;
    logic       alu_inc;
    logic       RL;
    logic       RR;
    logic       err;
    logic       skip;

    modport master (
        output start, opr, accminus, acczero, cyout,
        input  busy, done, clearacc, clearcy, compacc, compcy,
               accwrite, alu_inc, RL, RR, err, skip
    );

    modport slave (
        input  start, opr, accminus, acczero, cyout,
        output busy, done, clearacc, clearcy, compacc, compcy,
               accwrite, alu_inc, RL, RR, err, skip
    );
endinterface

// File: rtl/opr_sequencer.sv
// Serialises one operate microinstruction into single-cycle acc/cy strobes (CLA,CLL,CMA,CML,IAC,ROT).
// Optional OPR_SKIP_EN: enables the skip output from the latched SKP bit and the acc/cy flags.
module opr_sequencer #(
    parameter int ROT_DOUBLE = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    opr_sequencer_if.slave bus
);
    // opr bit positions: {CLA,CLL,CMA,CML,RAR,RAL,BSW,IAC,SKP}
    localparam int B_CLA = 8;
    localparam int B_CLL = 7;
    localparam int B_CMA = 6;
    localparam int B_CML = 5;
    localparam int B_RAR = 4;
    localparam int B_RAL = 3;
    localparam int B_BSW = 2;
    localparam int B_IAC = 1;
    localparam int B_SKP = 0;

    localparam logic [1:0] ROT_LAST_DOUBLE = 2'(ROT_DOUBLE - 1);

    // Step states are encoded so that step index i lives at state value i+1.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_CLA = 3'd1,
        S_CLL = 3'd2,
        S_CMA = 3'd3,
        S_CML = 3'd4,
        S_IAC = 3'd5,
        S_ROT = 3'd6,
        DONE  = 3'd7
    } state_t;

    state_t     state_reg, state_next;
    logic [8:0] opr_reg, opr_next;
    logic [1:0] cnt_reg, cnt_next;
    logic [1:0] rot_last;

    // Active-step vector in issue order, bit 0 = CLA ... bit 5 = ROT.
    function automatic logic [5:0] steps(input logic [8:0] op);
        return {op[B_RAL] ^ op[B_RAR], op[B_IAC], op[B_CML],
                op[B_CMA], op[B_CLL], op[B_CLA]};
    endfunction

    // First active step with index >= lo, or DONE when none remain.
    function automatic state_t seek(input logic [5:0] act, input logic [2:0] lo);
        state_t s;
        s = DONE;
        for (int i = 5; i >= 0; i--) begin
            if (3'(i) >= lo && act[i]) begin
                s = state_t'(3'(i + 1));
            end
        end
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            opr_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            opr_reg   <= opr_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign rot_last = opr_reg[B_BSW] ? ROT_LAST_DOUBLE : 2'd0;

    always_comb begin
        state_next = state_reg;
        opr_next   = opr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    opr_next   = bus.opr;
                    cnt_next   = 2'd0;
                    state_next = seek(steps(bus.opr), 3'd0);
                end
            end
            S_ROT: begin
                if (cnt_reg == rot_last) begin
                    cnt_next   = 2'd0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end
            DONE: state_next = IDLE;
            // Current state value is the index of the next step to consider.
            default: state_next = seek(steps(opr_reg), 3'(state_reg));
        endcase
    end

    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = (state_reg == DONE);
    assign bus.clearacc = (state_reg == S_CLA);
    assign bus.clearcy  = (state_reg == S_CLL);
    assign bus.compacc  = (state_reg == S_CMA);
    assign bus.compcy   = (state_reg == S_CML);
    assign bus.accwrite = (state_reg == S_IAC);
    assign bus.alu_inc  = (state_reg == S_IAC);
    assign bus.RL       = (state_reg == S_ROT) && opr_reg[B_RAL];
    assign bus.RR       = (state_reg == S_ROT) && opr_reg[B_RAR];
    assign bus.err      = (state_reg == DONE) && opr_reg[B_RAL] && opr_reg[B_RAR];

`ifdef OPR_SKIP_EN
    // Flags are read in DONE, after every strobe of this instruction has landed.
    assign bus.skip = (state_reg == DONE) && opr_reg[B_SKP]
                      && (bus.accminus || bus.acczero || bus.cyout);
`else
    logic unused_skip_inputs;
    assign unused_skip_inputs = ^{bus.accminus, bus.acczero, bus.cyout, opr_reg[B_SKP]};
    assign bus.skip = 1'b0;
`endif

endmodule
